hs_byte_tx: RTL and testbench
=============================

# hs_byte_tx

Valid/ready transmitter that accepts 32-bit words with a byte count on an upstream handshake and serializes them LSB-first onto an 8-bit valid/ready stream with a last-byte marker. It sits at the producing end of the 8-bit handshake pipeline and drives the stream's first register stage. It honours backpressure without loss or duplication and sustains one byte per cycle across word boundaries.

## Interface
- BYTES, 4: bytes per input word; fixed at 4 for this revision, and data_i is BYTES*8 wide.
- CNT_W, 16: width of the transferred-byte counter.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_pre_i  in  1  upstream word valid.
- ready_pre_o  out  1  block can accept a word this cycle.
- data_i  in  32  word; byte 0 = data_i[7:0], sent first.
- len_i  in  2  number of bytes to send minus 1 (0 = one byte, 3 = four bytes).
- valid_post_o  out  1  byte valid, registered.
- ready_post_i  in  1  downstream ready.
- data_o  out  8  byte, registered.
- last_o  out  1  marks the final byte of the current word, registered.
- byte_cnt_o  out  CNT_W  running count of completed output handshakes; wraps.

## Operation
- Upstream handshake: word accepted at a rising edge when valid_pre_i && ready_pre_o.
- Downstream handshake: byte transferred at a rising edge when valid_post_o && ready_post_i.
- State IDLE: valid_post_o = 0 and ready_pre_o = 1.
  - On word accept: latch data_i into the shift register and len_i into rem; drive data_o = data_i[7:0] and last_o = (len_i == 0); set valid_post_o = 1; go to SEND.
- State SEND: valid_post_o = 1. data_o and last_o stay stable until a downstream handshake.
  - On a handshake with last_o = 0: shift the register right 8 bits, present the next byte, decrement rem, and set last_o = (rem == 1).
  - On a handshake with last_o = 1: if valid_pre_i is high, accept the new word at the same edge and present its byte 0 (stay in SEND). Otherwise go to IDLE and clear valid_post_o.
- ready_pre_o = (state == IDLE) || (last_o && ready_post_i). This is combinational from ready_post_i, by design, to allow zero-bubble word chaining.
- byte_cnt_o increments by 1 per downstream handshake, modulo 2^CNT_W (0xFFFF -> 0x0000).
- Bytes of data_i above len_i are ignored and never appear on data_o.
- valid_post_o never drops without a handshake. data_o never changes while valid_post_o && !ready_post_i.

## Timing
- Reset values: valid_post_o = 0, data_o = 0x00, last_o = 0, byte_cnt_o = 0, state IDLE. ready_pre_o = 1 while reset is asserted and afterwards.
- Latency: a word accepted at edge N has byte 0 visible after edge N.
- A (len_i+1)-byte word with ready_post_i held high occupies exactly len_i+1 cycles on the output.
- Continuous upstream valid with no backpressure gives 100% output utilisation with no idle cycles between words.
- Backpressure: each cycle with ready_post_i low holds the output unchanged and stalls the upstream side (ready_pre_o = 0 in SEND, except on a last byte that is handshaking).
- Reset mid-word: the in-flight word is discarded and all outputs return to reset values asynchronously. No partial-word resume.

## Structure
- Shared package hs_pkg holds:
  - typedef tx_state_t {IDLE, SEND};
  - localparam BYTE_W = 8;
  - localparam LEN_W = 2.
- Single module, no sub-modules. Registers: state, shift register (32), rem (2), valid/data/last output flops, byte counter.
- Target size: roughly 150 lines of RTL.

## Test plan
- Reset: assert reset for 3 cycles, then release. Required: valid_post_o = 0, data_o = 0x00, last_o = 0, byte_cnt_o = 0, ready_pre_o = 1.
- Full word: data_i = 0x44332211, len_i = 3, ready_post_i held at 1. Required: bytes 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; last_o high only on 0x44; byte_cnt_o = 4.
- Backpressure: same word, with ready_post_i low for 3 cycles while 0x22 is presented. Required: 0x22 and valid_post_o held for 3 cycles, ready_pre_o = 0 throughout, no duplicated or lost bytes.
- Chaining: word 0xBBAA with len_i = 1, then word 0x000000CC with len_i = 0, valid_pre_i held continuously. Required: 0xAA, 0xBB(last), 0xCC(last) on 3 consecutive cycles, with the second word accepted at the edge where 0xBB handshakes.
- Counter wrap: preload traffic until byte_cnt_o = 0xFFFE, then send len_i = 1. Required: byte_cnt_o reads 0xFFFF, then 0x0000.
- Reset mid-word: assert reset after 0x22 of 0x44332211 has handshaken. Required: outputs return to reset values immediately; the next accepted word starts from its own byte 0.

Source files
------------

// File: rtl/hs_pkg.sv
// hs_pkg: shared types and widths for the 8-bit handshake stream blocks.
package hs_pkg;
    typedef enum logic {IDLE, SEND} tx_state_t;
    localparam int BYTE_W = 8;
    localparam int LEN_W = 2;
endpackage

// File: rtl/hs_byte_tx.sv
// hs_byte_tx: serializes upstream words LSB-first onto an 8-bit valid/ready stream with a last-byte marker.
module hs_byte_tx
    import hs_pkg::*;
#(
    parameter int BYTES = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_pre_i,
    output logic                    ready_pre_o,
    input  logic [BYTES*BYTE_W-1:0] data_i,
    input  logic [LEN_W-1:0]        len_i,
    output logic                    valid_post_o,
    input  logic                    ready_post_i,
    output logic [BYTE_W-1:0]       data_o,
    output logic                    last_o,
    output logic [CNT_W-1:0]        byte_cnt_o
);
    tx_state_t               state;
    logic [BYTES*BYTE_W-1:0] sr;
    logic [LEN_W-1:0]        rem;
    logic                    accept;
    logic                    xfer;

    // Combinational path from ready_post_i lets a new word load on the last byte's handshake.
    assign ready_pre_o = (state == IDLE) || (last_o && ready_post_i);
    assign accept      = valid_pre_i && ready_pre_o;
    assign xfer        = valid_post_o && ready_post_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sr           <= '0;
            rem          <= '0;
            valid_post_o <= 1'b0;
            data_o       <= '0;
            last_o       <= 1'b0;
        end else if (accept) begin
            state        <= SEND;
            sr           <= data_i;
            rem          <= len_i;
            valid_post_o <= 1'b1;
            data_o       <= data_i[BYTE_W-1:0];
            last_o       <= (len_i == '0);
        end else if (xfer && !last_o) begin
            sr     <= sr >> BYTE_W;
            rem    <= rem - 1'b1;
            data_o <= sr[2*BYTE_W-1:BYTE_W];
            last_o <= (rem == LEN_W'(1));
        end else if (xfer) begin
            state        <= IDLE;
            valid_post_o <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) byte_cnt_o <= '0;
        else if (xfer) byte_cnt_o <= byte_cnt_o + 1'b1;
    end
endmodule

// File: tb/tb_hs_byte_tx.sv
// tb_hs_byte_tx: directed and randomized checks of hs_byte_tx against a byte-queue reference model.
module tb_hs_byte_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_pre_i = 1'b0;
    logic        ready_pre_o;
    logic [31:0] data_i = '0;
    logic [1:0]  len_i = '0;
    logic        valid_post_o;
    logic        ready_post_i = 1'b0;
    logic [7:0]  data_o;
    logic        last_o;
    logic [15:0] byte_cnt_o;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } ent_t;
    ent_t        q[$];
    logic [15:0] mcnt = '0;

    hs_byte_tx #(.BYTES(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
        .data_i(data_i), .len_i(len_i),
        .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
        .data_o(data_o), .last_o(last_o), .byte_cnt_o(byte_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: the stream is a queue of pending bytes; one word at a time is in flight.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            mcnt = '0;
        end else begin
            logic exp_rdy;
            exp_rdy = (q.size() == 0) || (q[0].l && ready_post_i);
            total++;
            if (valid_post_o !== (q.size() != 0)) begin
                bad++;
                $display("FAIL mon_valid got=%b exp=%b", valid_post_o, q.size() != 0);
            end
            total++;
            if (ready_pre_o !== exp_rdy) begin
                bad++;
                $display("FAIL mon_ready_pre got=%b exp=%b", ready_pre_o, exp_rdy);
            end
            total++;
            if (byte_cnt_o !== mcnt) begin
                bad++;
                $display("FAIL mon_cnt got=%h exp=%h", byte_cnt_o, mcnt);
            end
            if (q.size() != 0) begin
                total++;
                if (data_o !== q[0].d || last_o !== q[0].l) begin
                    bad++;
                    $display("FAIL mon_byte got=%h/%b exp=%h/%b", data_o, last_o, q[0].d, q[0].l);
                end
                if (ready_post_i) begin
                    void'(q.pop_front());
                    mcnt = mcnt + 16'd1;
                end
            end
            if (valid_pre_i && exp_rdy)
                for (int i = 0; i <= int'(len_i); i++)
                    q.push_back('{d: data_i[8*i +: 8], l: (i == int'(len_i))});
        end
    end

    task automatic drain();
        int n = 0;
        valid_pre_i = 1'b0;
        ready_post_i = 1'b1;
        @(negedge clk);
        while (valid_post_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (valid_post_o !== 1'b0) begin
            bad++;
            $display("FAIL drain_timeout got=%b exp=0", valid_post_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_one(input logic [31:0] w, input logic [1:0] l);
        @(posedge clk); #1;
        valid_pre_i = 1'b1; data_i = w; len_i = l; ready_post_i = 1'b1;
        @(posedge clk); #1;
        valid_pre_i = 1'b0;
        drain();
    endtask

    task automatic check_reset_vals(input string nm);
        total++;
        if ({valid_post_o, data_o, last_o, byte_cnt_o, ready_pre_o} !== {1'b0, 8'h00, 1'b0, 16'h0000, 1'b1}) begin
            bad++;
            $display("FAIL %s got v=%b d=%h l=%b c=%h r=%b exp v=0 d=00 l=0 c=0000 r=1",
                     nm, valid_post_o, data_o, last_o, byte_cnt_o, ready_pre_o);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset_held");
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_released");
    endtask

    task automatic test_full_word();
        logic [31:0] w = 32'h44332211;
        logic [15:0] c0 = byte_cnt_o;
        @(posedge clk); #1;
        valid_pre_i = 1'b1; data_i = w; len_i = 2'd3; ready_post_i = 1'b1;
        @(posedge clk); #1;
        valid_pre_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (valid_post_o !== 1'b1 || data_o !== w[8*i +: 8] || last_o !== (i == 3)) begin
                bad++;
                $display("FAIL full_byte%0d got=%b/%h/%b exp=1/%h/%b", i, valid_post_o, data_o, last_o, w[8*i +: 8], i == 3);
            end
        end
        @(negedge clk);
        total++;
        if (valid_post_o !== 1'b0 || byte_cnt_o !== c0 + 16'd4) begin
            bad++;
            $display("FAIL full_end got v=%b c=%h exp v=0 c=%h", valid_post_o, byte_cnt_o, c0 + 16'd4);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] c0 = byte_cnt_o;
        @(posedge clk); #1;
        valid_pre_i = 1'b1; data_i = 32'h44332211; len_i = 2'd3; ready_post_i = 1'b1;
        @(posedge clk); #1;
        valid_pre_i = 1'b1;
        data_i = 32'h99999999;
        @(posedge clk); #1;
        ready_post_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (valid_post_o !== 1'b1 || data_o !== 8'h22 || ready_pre_o !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got v=%b d=%h r=%b exp v=1 d=22 r=0", k, valid_post_o, data_o, ready_pre_o);
            end
            @(posedge clk); #1;
        end
        ready_post_i = 1'b1;
        valid_pre_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] e;
            e = 8'h22 + 8'(i) * 8'h11;
            @(negedge clk);
            total++;
            if (data_o !== e || last_o !== (i == 2)) begin
                bad++;
                $display("FAIL bp_byte%0d got=%h/%b exp=%h/%b", i, data_o, last_o, e, i == 2);
            end
        end
        @(negedge clk);
        total++;
        if (valid_post_o !== 1'b0 || byte_cnt_o !== c0 + 16'd4) begin
            bad++;
            $display("FAIL bp_end got v=%b c=%h exp v=0 c=%h", valid_post_o, byte_cnt_o, c0 + 16'd4);
        end
    endtask

    task automatic test_chain();
        @(posedge clk); #1;
        valid_pre_i = 1'b1; data_i = 32'h0000BBAA; len_i = 2'd1; ready_post_i = 1'b1;
        @(posedge clk); #1;
        data_i = 32'h000000CC; len_i = 2'd0;
        @(negedge clk);
        total++;
        if (data_o !== 8'hAA || last_o !== 1'b0 || ready_pre_o !== 1'b0) begin
            bad++;
            $display("FAIL chain_aa got=%h/%b r=%b exp=aa/0 r=0", data_o, last_o, ready_pre_o);
        end
        @(negedge clk);
        total++;
        if (data_o !== 8'hBB || last_o !== 1'b1 || ready_pre_o !== 1'b1) begin
            bad++;
            $display("FAIL chain_bb got=%h/%b r=%b exp=bb/1 r=1", data_o, last_o, ready_pre_o);
        end
        @(posedge clk); #1;
        valid_pre_i = 1'b0;
        @(negedge clk);
        total++;
        if (valid_post_o !== 1'b1 || data_o !== 8'hCC || last_o !== 1'b1) begin
            bad++;
            $display("FAIL chain_cc got=%b/%h/%b exp=1/cc/1", valid_post_o, data_o, last_o);
        end
        @(negedge clk);
        total++;
        if (valid_post_o !== 1'b0) begin
            bad++;
            $display("FAIL chain_end got=%b exp=0", valid_post_o);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            valid_pre_i = ($urandom_range(0, 3) != 0);
            data_i = $urandom;
            len_i = 2'($urandom_range(0, 3));
            ready_post_i = ($urandom_range(0, 3) != 0);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        valid_pre_i = 1'b1; data_i = 32'h44332211; len_i = 2'd3; ready_post_i = 1'b1;
        @(posedge clk); #1;
        valid_pre_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1 check_reset_vals("rst_mid_async");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        valid_pre_i = 1'b1; data_i = 32'h00776655; len_i = 2'd2;
        @(posedge clk); #1;
        valid_pre_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (data_o !== 8'h55 + 8'(i) * 8'h11 || last_o !== (i == 2)) begin
                bad++;
                $display("FAIL rst_mid_byte%0d got=%h/%b exp=%h/%b", i, data_o, last_o, 8'h55 + 8'(i) * 8'h11, i == 2);
            end
        end
        @(negedge clk);
        total++;
        if (byte_cnt_o !== 16'd3) begin
            bad++;
            $display("FAIL rst_mid_cnt got=%h exp=0003", byte_cnt_o);
        end
    endtask

    task automatic test_wrap();
        int guard = 0;
        @(posedge clk); #1;
        valid_pre_i = 1'b1; len_i = 2'd3; ready_post_i = 1'b1; data_i = $urandom;
        while (guard < 70000) begin
            @(negedge clk);
            if (byte_cnt_o >= 16'hFF00) break;
            @(posedge clk); #1;
            data_i = $urandom;
            guard++;
        end
        drain();
        guard = 0;
        while (byte_cnt_o != 16'hFFFE && guard < 1000) begin
            send_one($urandom, 2'd0);
            guard++;
        end
        total++;
        if (byte_cnt_o !== 16'hFFFE) begin
            bad++;
            $display("FAIL wrap_preload got=%h exp=fffe", byte_cnt_o);
        end
        @(posedge clk); #1;
        valid_pre_i = 1'b1; data_i = $urandom; len_i = 2'd1;
        @(posedge clk); #1;
        valid_pre_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (byte_cnt_o !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_ffff got=%h exp=ffff", byte_cnt_o);
        end
        @(negedge clk);
        total++;
        if (byte_cnt_o !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_zero got=%h exp=0000", byte_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_backpressure();
        test_chain();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
